sysid_boot_checker: RTL and testbench

Avalon-MM read master that sits directly upstream of the Qsys system-ID slave and consumes its 32-bit readdata. After reset, or on a start pulse, it reads word 0 (system ID) and word 1 (build timestamp), compares both against expected values, and retries on mismatch or timeout. It presents latched values and pass/fail status to the NIOS-side status PIO and the board LEDs, so a stale FPGA image is flagged before software runs.

---
 rtl/sysid_boot_checker.sv | 160 ++++++++++++++++
 tb/tb_sysid_boot_checker.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_boot_checker.sv
// Boot-time image check: reads the Qsys system-ID slave (ID word, then build
// timestamp), compares both to expected values, retries on mismatch or stall timeout.
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1476570444,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        match,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [2:0]  retries_used,
  output logic        timeout_err
);

  // state  | meaning
  // IDLE   | waiting for start (or the one-shot auto start after reset)
  // REQ_ID | avm_read high at address 0, waiting for waitrequest low
  // LAT_ID | counting read latency before sampling the ID word
  // REQ_TS | avm_read high at address 1, waiting for waitrequest low
  // LAT_TS | counting read latency before sampling the timestamp word
  // CHECK  | compare captured words, decide retry or finish
  // FINISH | done pulse, status outputs updated
  typedef enum logic [2:0] {
    IDLE, REQ_ID, LAT_ID, REQ_TS, LAT_TS, CHECK, FINISH
  } state_t;

  localparam logic [2:0]  RETRY_MAX = 3'(MAX_RETRIES);
  localparam logic [15:0] WAIT_LOAD = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  LAT_LOAD  = 2'(READ_LATENCY - 1);
  localparam bit          ZERO_LAT  = (READ_LATENCY == 0);

  state_t      state;
  logic [15:0] wait_cnt;
  logic [1:0]  lat_cnt;
  logic        to_flag;
  logic        auto_pend;
  logic        check_pass;

  assign check_pass = (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS) && !to_flag;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      avm_read     <= 1'b0;
      avm_address  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      match        <= 1'b0;
      timeout_err  <= 1'b0;
      id_value     <= '0;
      ts_value     <= '0;
      retries_used <= '0;
      wait_cnt     <= '0;
      lat_cnt      <= '0;
      to_flag      <= 1'b0;
      auto_pend    <= AUTO_START;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start || auto_pend) begin
            auto_pend    <= 1'b0;
            state        <= REQ_ID;
            avm_read     <= 1'b1;
            avm_address  <= 1'b0;
            busy         <= 1'b1;
            match        <= 1'b0;
            timeout_err  <= 1'b0;
            retries_used <= '0;
            to_flag      <= 1'b0;
            wait_cnt     <= WAIT_LOAD;
          end
        end
        REQ_ID, REQ_TS: begin
          if (avm_waitrequest) begin
            // wait_cnt reaching zero marks the TIMEOUT_CYCLES-th stalled cycle
            if (wait_cnt == '0) begin
              avm_read <= 1'b0;
              to_flag  <= 1'b1;
              state    <= CHECK;
            end else begin
              wait_cnt <= wait_cnt - 16'd1;
            end
          end else begin
            lat_cnt <= LAT_LOAD;
            if (ZERO_LAT) begin
              if (state == REQ_ID) begin
                id_value    <= avm_readdata;
                avm_address <= 1'b1;
                wait_cnt    <= WAIT_LOAD;
                state       <= REQ_TS;
              end else begin
                ts_value <= avm_readdata;
                avm_read <= 1'b0;
                state    <= CHECK;
              end
            end else begin
              avm_read <= 1'b0;
              state    <= (state == REQ_ID) ? LAT_ID : LAT_TS;
            end
          end
        end
        LAT_ID, LAT_TS: begin
          if (lat_cnt == '0) begin
            if (state == LAT_ID) begin
              id_value    <= avm_readdata;
              avm_read    <= 1'b1;
              avm_address <= 1'b1;
              wait_cnt    <= WAIT_LOAD;
              state       <= REQ_TS;
            end else begin
              ts_value <= avm_readdata;
              state    <= CHECK;
            end
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        CHECK: begin
          if (check_pass) begin
            state       <= FINISH;
            done        <= 1'b1;
            match       <= 1'b1;
            timeout_err <= 1'b0;
          end else if (retries_used < RETRY_MAX) begin
            retries_used <= retries_used + 3'd1;
            state        <= REQ_ID;
            avm_read     <= 1'b1;
            avm_address  <= 1'b0;
            to_flag      <= 1'b0;
            wait_cnt     <= WAIT_LOAD;
          end else begin
            state       <= FINISH;
            done        <= 1'b1;
            match       <= 1'b0;
            timeout_err <= to_flag;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Bench for sysid_boot_checker: instance A (latency 1, 3 retries, timeout 4, auto start)
// checked every cycle against a timeline model; instance B (latency 0, no retries) by directed traces.
module tb_sysid_boot_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1476570444;
  localparam int A_TO  = 4;
  localparam int A_MAX = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A ----------------
  logic        a_start, a_addr, a_read, a_wait, a_busy, a_done, a_match, a_to;
  logic [31:0] a_rdata = '0;
  logic [31:0] a_id, a_ts;
  logic [2:0]  a_ret;

  sysid_boot_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .READ_LATENCY(1),
    .MAX_RETRIES(A_MAX), .TIMEOUT_CYCLES(A_TO), .AUTO_START(1'b1)
  ) dut_a (
    .clock(clk), .reset(reset), .start(a_start),
    .avm_address(a_addr), .avm_read(a_read), .avm_waitrequest(a_wait),
    .avm_readdata(a_rdata), .busy(a_busy), .done(a_done), .match(a_match),
    .id_value(a_id), .ts_value(a_ts), .retries_used(a_ret), .timeout_err(a_to)
  );

  // slave A: stalls a_stall cycles per read (or forever), returns data one cycle after acceptance
  logic        a_stuck   = 1'b0;
  int          a_stall   = 0;
  logic [31:0] a_id_word = EXP_ID;
  int          a_bad     = 0;
  int          a_ts_base = 0;
  int          a_ts_reads = 0;
  int          a_stall_cnt = 0;
  int          a_accepts = 0;

  assign a_wait = a_stuck || (a_stall_cnt < a_stall);

  always @(posedge clk) begin
    if (a_read && a_wait) a_stall_cnt <= a_stall_cnt + 1;
    else                  a_stall_cnt <= 0;
    if (a_read && !a_wait) begin
      a_accepts <= a_accepts + 1;
      if (a_addr) begin
        a_rdata    <= ((a_ts_reads - a_ts_base) < a_bad) ? EXP_TS + 32'd1 : EXP_TS;
        a_ts_reads <= a_ts_reads + 1;
      end else begin
        a_rdata <= a_id_word;
      end
    end else begin
      a_rdata <= 32'hDEAD_BEEF;
    end
  end

  // ---------------- instance B ----------------
  logic        b_start, b_addr, b_read, b_wait, b_busy, b_done, b_match, b_to;
  logic [31:0] b_rdata, b_id, b_ts;
  logic [2:0]  b_ret;
  logic        b_stuck   = 1'b0;
  logic [31:0] b_id_word = EXP_ID;

  assign b_wait  = b_stuck;
  assign b_rdata = b_addr ? EXP_TS : b_id_word;

  sysid_boot_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .READ_LATENCY(0),
    .MAX_RETRIES(0), .TIMEOUT_CYCLES(4), .AUTO_START(1'b0)
  ) dut_b (
    .clock(clk), .reset(reset), .start(b_start),
    .avm_address(b_addr), .avm_read(b_read), .avm_waitrequest(b_wait),
    .avm_readdata(b_rdata), .busy(b_busy), .done(b_done), .match(b_match),
    .id_value(b_id), .ts_value(b_ts), .retries_used(b_ret), .timeout_err(b_to)
  );

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
  endtask

  logic        chk_en = 1'b0;
  logic        exp_read, exp_addr, exp_busy, exp_done, exp_match, exp_to;
  logic [2:0]  exp_retries;
  logic [31:0] exp_id, exp_ts;

  always @(negedge clk) begin
    if (chk_en)
      check("cycle_a",
            {a_read, exp_read & a_addr, a_busy, a_done, a_match, a_to, a_ret, a_id, a_ts},
            {exp_read, exp_read & exp_addr, exp_busy, exp_done, exp_match, exp_to,
             exp_retries, exp_id, exp_ts});
  end

  int last_done_cyc = 0;
  always @(negedge clk) if (a_done) last_done_cyc = cyc;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_reset();
    exp_read = 0; exp_addr = 0; exp_busy = 0; exp_done = 0; exp_match = 0;
    exp_to = 0; exp_retries = '0; exp_id = '0; exp_ts = '0;
  endtask

  // Timeline of one check sequence on instance A, entered in its first busy cycle.
  // Each pass: per word, stall+1 request cycles, one latency cycle; then one check cycle.
  task automatic model_sequence();
    int  pass_idx = 0;
    bit  tmo, ok;
    exp_busy = 1; exp_done = 0; exp_match = 0; exp_to = 0; exp_retries = '0;
    while (1) begin
      tmo = 0;
      for (int a = 0; a < 2 && !tmo; a++) begin
        exp_read = 1;
        exp_addr = (a == 1);
        if (a_stuck) begin
          repeat (A_TO) step();
          tmo = 1;
        end else begin
          repeat (a_stall + 1) step();
          exp_read = 0;
          step();
          if (a == 0) exp_id = a_id_word;
          else        exp_ts = (pass_idx < a_bad) ? EXP_TS + 32'd1 : EXP_TS;
        end
      end
      exp_read = 0;
      ok = (exp_id == EXP_ID) && (exp_ts == EXP_TS) && !tmo;
      step();
      if (ok || exp_retries == 3'(A_MAX)) begin
        exp_done = 1; exp_match = ok; exp_to = tmo;
        step();
        exp_done = 0; exp_busy = 0;
        break;
      end
      exp_retries = exp_retries + 3'd1;
      pass_idx++;
    end
  endtask

  task automatic pulse_a_start();
    a_start = 1;
    step();
    a_start = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  int rel_cyc, acc0, rd_cnt, addr1_cnt, dn_cnt, done_idx;
  logic rd_tr [0:11];
  logic ad_tr [0:11];

  initial begin
    reset = 1; a_start = 0; b_start = 0;
    exp_reset();
    repeat (2) step();
    chk_en = 1;
    check("reset_id", 73'(a_id), 73'd0);

    // S1: auto start after reset, zero-wait slave, correct words
    reset = 0;
    step();
    rel_cyc = cyc;
    model_sequence();
    check("s1_done_cycle", 73'(last_done_cyc - rel_cyc + 1), 73'd6);
    check("s1_ts", 73'(a_ts), 73'(32'd1476570444));
    check("s1_match", 73'(a_match), 73'd1);

    // S2: timestamp wrong forever -> four full passes
    a_bad = 99; a_ts_base = a_ts_reads; acc0 = a_accepts;
    pulse_a_start();
    model_sequence();
    check("s2_accepts", 73'(a_accepts - acc0), 73'd8);
    check("s2_retries", 73'(a_ret), 73'd3);
    check("s2_ts", 73'(a_ts), 73'(32'd1476570445));
    check("s2_timeout", 73'(a_to), 73'd0);

    // S3: start in the cycle right after FINISH; wrong TS on first pass only
    a_bad = 1; a_ts_base = a_ts_reads;
    pulse_a_start();
    model_sequence();
    check("s3_retries", 73'(a_ret), 73'd1);
    check("s3_match", 73'(a_match), 73'd1);

    // S4: three stall cycles per read, one short of the timeout
    a_bad = 0; a_stall = 3;
    pulse_a_start();
    model_sequence();
    check("s4_match", 73'(a_match), 73'd1);

    // S5: waitrequest stuck -> every pass times out on the ID read
    a_stuck = 1;
    pulse_a_start();
    model_sequence();
    check("s5_timeout", 73'(a_to), 73'd1);
    check("s5_retries", 73'(a_ret), 73'd3);
    check("s5_ts_kept", 73'(a_ts), 73'(EXP_TS));

    // S6: wrong ID word, one stall cycle per read
    a_stuck = 0; a_stall = 1; a_id_word = 32'h1234_5678;
    pulse_a_start();
    model_sequence();
    check("s6_id", 73'(a_id), 73'(32'h1234_5678));
    check("s6_match", 73'(a_match), 73'd0);

    // S7: reset while in LAT_TS, then auto start again
    a_stall = 0; a_id_word = EXP_ID;
    chk_en = 0;
    pulse_a_start();
    repeat (3) step();
    reset = 1;
    step();
    exp_reset();
    chk_en = 1;
    check("s7_busy", 73'(a_busy), 73'd0);
    step();
    reset = 0;
    step();
    model_sequence();
    check("s7_match", 73'(a_match), 73'd1);
    chk_en = 0;

    // B1: stuck waitrequest, no retries; ID word on the bus must not be captured
    b_stuck = 1; b_id_word = 32'hBAD0_0001;
    @(negedge clk); b_start = 1;
    @(negedge clk); b_start = 0;
    rd_cnt = 0; addr1_cnt = 0; dn_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (b_read) begin rd_cnt++; if (b_addr) addr1_cnt++; end
      if (b_done) dn_cnt++;
      @(negedge clk);
    end
    check("b1_read_cycles", 73'(rd_cnt), 73'd4);
    check("b1_addr1", 73'(addr1_cnt), 73'd0);
    check("b1_done_cnt", 73'(dn_cnt), 73'd1);
    check("b1_status", {70'd0, b_match, b_to, b_busy}, {70'd0, 1'b0, 1'b1, 1'b0});
    check("b1_id", 73'(b_id), 73'd0);

    // B2: zero latency back-to-back reads; start while busy and in FINISH is dropped
    b_stuck = 0; b_id_word = EXP_ID;
    b_start = 1;
    @(negedge clk);
    rd_cnt = 0; dn_cnt = 0; done_idx = -1;
    for (int i = 0; i < 12; i++) begin
      b_start = (i >= 1 && i <= 3);
      rd_tr[i] = b_read;
      ad_tr[i] = b_addr;
      if (b_read) rd_cnt++;
      if (b_done) begin dn_cnt++; done_idx = i; end
      @(negedge clk);
    end
    b_start = 0;
    check("b2_trace", {67'd0, rd_tr[0], ad_tr[0], rd_tr[1], ad_tr[1], rd_tr[2], rd_tr[3]},
                      {67'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    check("b2_read_cycles", 73'(rd_cnt), 73'd2);
    check("b2_done_cnt", 73'(dn_cnt), 73'd1);
    check("b2_done_idx", 73'(done_idx), 73'd3);
    check("b2_status", {70'd0, b_match, b_to, b_busy}, {70'd0, 1'b1, 1'b0, 1'b0});
    check("b2_ts", 73'(b_ts), 73'(EXP_TS));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
